glyph_overlay: RTL and testbench
================================

Name: glyph_overlay

Overview:
- Pixel-pipeline stage that sits between the VGA timing generator and the VGA pins.
- Drives the 6-bit row address of the 64x64 glyph ROM (the panel-label bitmap), registers the returned 64-bit row and selects the current column bit.
- Mixes the lit glyph pixels over the incoming scope background colour, with optional integer scaling and frame-based blinking.
- Delays sync signals so that colour and sync leave the block aligned.

Parameters:
- X0, 288: left edge of glyph window, in pixels (hc units).
- Y0, 208: top edge of glyph window, in lines (vc units).
- SCALE_LOG2, 0: window magnification of 2^SCALE_LOG2 (legal 0..2); window is (64<<SCALE_LOG2) square.
- FG_RGB, 12'hFFF: colour of lit glyph pixels.
- BLINK_FRAMES, 30: frames per blink phase; 0 = no blinking (always visible).

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst_n  in  1  asynchronous active-low reset.
- hc  in  10  horizontal pixel counter from the timing generator.
- vc  in  10  vertical line counter.
- vidon  in  1  1 = visible area.
- hsync_in  in  1  active-low horizontal sync.
- vsync_in  in  1  active-low vertical sync.
- bg_rgb  in  12  background/trace colour for this pixel.
- overlay_en  in  1  1 = draw glyphs.
- addr_F  out  6  glyph ROM row address (combinational).
- F_row  in  64  glyph ROM row data, bit index 0 = leftmost pixel; ROM is combinational.
- rgb  out  12  final colour to the DAC pins.
- hsync  out  1  delayed hsync.
- vsync  out  1  delayed vsync.

Behaviour:
- Window test (combinational):
  - hwin = (hc >= X0) && (hc < X0 + (64<<SCALE_LOG2)).
  - vwin is the same test on vc against Y0.
  - All comparisons use 11-bit unsigned arithmetic, so no wrap occurs at X0+width > 1023.
- addr_F = ((vc - Y0) >> SCALE_LOG2)[5:0] when vwin, else 6'd0.
- Stage 1 register, every clk:
  - row_q <= F_row
  - col_q <= ((hc - X0) >> SCALE_LOG2)[5:0]
  - win_q <= hwin && vwin
  - vid_q <= vidon
  - hs_q <= hsync_in
  - vs_q <= vsync_in
  - bg_q <= bg_rgb
- Stage 2 register, every clk:
  - hsync <= hs_q and vsync <= vs_q.
  - rgb <= 12'h000 if !vid_q.
  - Otherwise rgb <= FG_RGB if (win_q && overlay_en && blink_on && row_q[col_q]).
  - Otherwise rgb <= bg_q.
- Latency: exactly 2 clk from hc/vc/vidon/syncs/bg_rgb to rgb/hsync/vsync, for every pixel. No bubbles, no stalls.
- overlay_en is sampled at stage 2 with no delay. A toggle mid-line affects pixels from the next stage-2 edge on; this is accepted.
- Blink logic:
  - vs_d registers vsync_in.
  - frame_tick = vs_d & ~vsync_in, i.e. a falling edge, one pulse per frame.
  - On frame_tick with BLINK_FRAMES != 0: if frame_cnt == BLINK_FRAMES-1, then frame_cnt <= 0 and blink_on <= ~blink_on; else frame_cnt <= frame_cnt+1.
  - frame_cnt width is clog2(BLINK_FRAMES+1), minimum 1.
  - BLINK_FRAMES == 0: blink_on is held at 1 and frame_cnt at 0.
- Reset values (asynchronous, rst_n low):
  - rgb = 0, hsync = 1, vsync = 1.
  - hs_q = vs_q = vs_d = 1.
  - row_q = 0, col_q = 0, win_q = 0, vid_q = 0, bg_q = 0.
  - frame_cnt = 0, blink_on = 1.
  - Release is effective on the first clk edge after rst_n rises. The pipeline refills in 2 clk and no spurious sync pulse is generated.
- Boundaries:
  - hc == X0 selects col 0 (bit 0).
  - hc == X0+(64<<S)-1 selects col 63.
  - hc == X0+(64<<S) is outside the window, so background is shown.
  - With SCALE_LOG2=1, each ROM bit covers 2 pixels and each ROM row covers 2 lines.
  - A pixel inside the window with vidon=0 outputs black; blanking has priority over the glyph.

Test Plan:
- Alignment: reset, release, sweep hc 0..799 and vc 0..524 with bench ROM = all ones, bg_rgb = 12'h0F0, overlay_en=1, BLINK_FRAMES=0.
  - rgb = 12'hFFF exactly for hc 288..351 and vc 208..271, delayed 2 clk.
  - rgb = 12'h0F0 elsewhere in the visible area.
  - hsync/vsync equal the inputs delayed 2 clk.
- Bit order: ROM row 0 = only bit 7 set; hc=295, vc=208 -> addr_F=0 and rgb=FG_RGB 2 clk later.
  - hc=294 and hc=296 give bg_rgb.
  - hc=288 with row 0 bit 0 clear gives bg_rgb.
- Scaling (SCALE_LOG2=1):
  - vc=209 -> addr_F=0; vc=210 -> addr_F=1.
  - hc=302 and hc=303 both map to col 7 and show FG when bit 7 is set.
  - hc=415 is the last window pixel; hc=416 gives bg.
- Blanking/enable:
  - vidon=0 inside the window -> rgb=12'h000.
  - overlay_en=0 inside the window with bit set -> rgb=bg_rgb.
- Blink (BLINK_FRAMES=2): generate 6 vsync falling edges.
  - blink_on sequence after each edge: 1,0,0,1,1,0 (toggles on edges 2, 4, 6).
  - Glyph pixels show bg while blink_on=0.
- Reset mid-frame: assert rst_n=0 while hsync_in=0 inside the window.
  - rgb=0 and hsync=vsync=1 immediately, without waiting for clk.
  - After release, outputs track the inputs with 2 clk latency and blink_on=1.

Source files
------------

// File: rtl/glyph_overlay.sv
// glyph_overlay: two-stage pixel pipeline that overlays a 64x64 glyph bitmap
// (optionally scaled and blinking) on the incoming background colour, keeping
// colour and sync aligned at a fixed two-clock latency.
module glyph_overlay #(
    parameter int unsigned X0           = 288,
    parameter int unsigned Y0           = 208,
    parameter int unsigned SCALE_LOG2   = 0,
    parameter logic [11:0] FG_RGB       = 12'hFFF,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hc,
    input  logic [9:0]  vc,
    input  logic        vidon,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] bg_rgb,
    input  logic        overlay_en,
    output logic [5:0]  addr_F,
    input  logic [63:0] F_row,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync
);

    // Window geometry in 11 bits so X0 + width never wraps past 1023.
    localparam logic [10:0] X0_W  = 11'(X0);
    localparam logic [10:0] Y0_W  = 11'(Y0);
    localparam logic [10:0] WIN_W = 11'(64 << SCALE_LOG2);
    localparam int unsigned FCW   = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);

    logic [10:0] hc_x, vc_x;
    logic        hwin, vwin;

    // Stage 1 state
    logic [63:0] row_d, row_q;
    logic [5:0]  col_d, col_q;
    logic        win_d, win_q;
    logic        vid_d, vid_q;
    logic        hs_d, hs_q;
    logic        vs_d, vs_q;
    logic [11:0] bg_d, bg_q;

    // Stage 2 state
    logic [11:0] rgb_d, rgb_q;
    logic        hsync_d, hsync_q;
    logic        vsync_d, vsync_q;

    // Blink state
    logic           frame_tick;
    logic [FCW-1:0] frame_cnt_d, frame_cnt_q;
    logic           blink_on_d, blink_on_q;

    // Window test and ROM row address for the current line.
    always_comb begin
        hc_x   = {1'b0, hc};
        vc_x   = {1'b0, vc};
        hwin   = (hc_x >= X0_W) && (hc_x < X0_W + WIN_W);
        vwin   = (vc_x >= Y0_W) && (vc_x < Y0_W + WIN_W);
        addr_F = vwin ? 6'((vc_x - Y0_W) >> SCALE_LOG2) : 6'd0;
    end

    // Stage 1: capture the ROM row alongside everything else for this pixel.
    always_comb begin
        row_d = F_row;
        col_d = 6'((hc_x - X0_W) >> SCALE_LOG2);
        win_d = hwin && vwin;
        vid_d = vidon;
        hs_d  = hsync_in;
        vs_d  = vsync_in;
        bg_d  = bg_rgb;
    end

    // Stage 2: blanking beats glyph, glyph beats background.
    always_comb begin
        hsync_d = hs_q;
        vsync_d = vs_q;
        if (!vid_q) begin
            rgb_d = 12'h000;
        end else if (win_q && overlay_en && blink_on_q && row_q[col_q]) begin
            rgb_d = FG_RGB;
        end else begin
            rgb_d = bg_q;
        end
    end

    // Blink phase counter; vs_q already holds last cycle's vsync_in, so it
    // doubles as the edge-detect delay for the frame tick.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        frame_cnt_d = frame_cnt_q;
        blink_on_d  = blink_on_q;
        frame_tick  = vs_q & ~vsync_in;
        if (BLINK_FRAMES == 0) begin
            frame_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (frame_tick) begin
            if (frame_cnt_q == FCW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    // Pipeline registers; syncs reset inactive (high) so release makes no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            row_q   <= '0;
            col_q   <= '0;
            win_q   <= 1'b0;
            vid_q   <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            bg_q    <= '0;
            rgb_q   <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            win_q   <= win_d;
            vid_q   <= vid_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            bg_q    <= bg_d;
            rgb_q   <= rgb_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    // Blink registers; glyph starts visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_glyph_overlay.sv
// tb_glyph_overlay: directed self-checking bench for glyph_overlay using three
// instances (unscaled/no blink, 2x scaled, 2-frame blink) on shared inputs.
module tb_glyph_overlay;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hc, vc;
    logic        vidon, hsync_in, vsync_in, overlay_en;
    logic [11:0] bg_rgb;

    logic [5:0]  addr_f0, addr_f1, addr_f2;
    logic [63:0] f_row0, f_row1, f_row2;
    logic [11:0] rgb0, rgb1, rgb2;
    logic        hs0, hs1, hs2, vs0, vs1, vs2;

    logic [63:0] rom [64];

    int n_checks = 0;
    int n_errors = 0;

    always #20 clk = ~clk;

    assign f_row0 = rom[addr_f0];
    assign f_row1 = rom[addr_f1];
    assign f_row2 = rom[addr_f2];

    glyph_overlay #(.SCALE_LOG2(0), .BLINK_FRAMES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .vidon(vidon),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
        .overlay_en(overlay_en), .addr_F(addr_f0), .F_row(f_row0),
        .rgb(rgb0), .hsync(hs0), .vsync(vs0));

    glyph_overlay #(.SCALE_LOG2(1), .BLINK_FRAMES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .vidon(vidon),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
        .overlay_en(overlay_en), .addr_F(addr_f1), .F_row(f_row1),
        .rgb(rgb1), .hsync(hs1), .vsync(vs1));

    glyph_overlay #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .vidon(vidon),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .bg_rgb(bg_rgb),
        .overlay_en(overlay_en), .addr_F(addr_f2), .F_row(f_row2),
        .rgb(rgb2), .hsync(hs2), .vsync(vs2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one pixel (syncs inactive) and wait until its result is on the outputs.
    task automatic pix(input int h, input int v, input logic vid, input logic en,
                       input logic [11:0] bg);
        hc = 10'(h); vc = 10'(v); vidon = vid; overlay_en = en; bg_rgb = bg;
        hsync_in = 1'b1; vsync_in = 1'b1;
        tick(2);
    endtask

    task automatic reset_pulse();
        #5 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        int          lines [7] = '{0, 207, 208, 271, 272, 479, 490};
        bit          blink_exp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [11:0] prev_rgb, e_rgb;
        logic        prev_hs, prev_vs, e_hs, e_vs, e_vid;
        int          n;

        foreach (rom[i]) rom[i] = '1;
        rst_n = 1'b0; hc = '0; vc = '0; vidon = 1'b0; overlay_en = 1'b1;
        bg_rgb = 12'h0F0; hsync_in = 1'b0; vsync_in = 1'b0;

        // Reset state with syncs driven active: outputs must stay idle.
        tick(2);
        check("reset_rgb", rgb0, 12'h000);
        check("reset_hsync", hs0, 1'b1);
        check("reset_vsync", vs0, 1'b1);
        hsync_in = 1'b1; vsync_in = 1'b1;
        #5 rst_n = 1'b1;
        tick(1);

        // Alignment sweep over selected full lines with an all-ones ROM.
        n = 0;
        foreach (lines[li]) begin
            for (int h = 0; h < 800; h++) begin
                int v;
                v = lines[li];
                e_vid = (h < 640) && (v < 480);
                e_hs  = !((h >= 656) && (h < 752));
                e_vs  = !((v == 490) || (v == 491));
                hc = 10'(h); vc = 10'(v); vidon = e_vid; bg_rgb = 12'h0F0;
                overlay_en = 1'b1; hsync_in = e_hs; vsync_in = e_vs;
                if (!e_vid) e_rgb = 12'h000;
                else if (h >= 288 && h <= 351 && v >= 208 && v <= 271) e_rgb = 12'hFFF;
                else e_rgb = 12'h0F0;
                tick(1);
                if (n > 0) begin
                    check("sweep_rgb", rgb0, prev_rgb);
                    check("sweep_hsync", hs0, prev_hs);
                    check("sweep_vsync", vs0, prev_vs);
                end
                prev_rgb = e_rgb; prev_hs = e_hs; prev_vs = e_vs;
                n++;
            end
        end

        // Bit order and window edges: ROM row 0 has bits 7 and 63 set.
        foreach (rom[i]) rom[i] = '0;
        rom[0] = 64'h8000_0000_0000_0080;
        pix(295, 208, 1, 1, 12'h123);
        check("bit7_addr", addr_f0, 6'd0);
        check("bit7_fg", rgb0, 12'hFFF);
        pix(294, 208, 1, 1, 12'h123); check("bit6_bg", rgb0, 12'h123);
        pix(296, 208, 1, 1, 12'h123); check("bit8_bg", rgb0, 12'h123);
        pix(288, 208, 1, 1, 12'h123); check("col0_bg", rgb0, 12'h123);
        pix(351, 208, 1, 1, 12'h123); check("col63_fg", rgb0, 12'hFFF);
        pix(352, 208, 1, 1, 12'h123); check("past_right_bg", rgb0, 12'h123);
        pix(295, 272, 1, 1, 12'h123); check("below_bg", rgb0, 12'h123);

        // 2x scaling on dut1.
        pix(302, 209, 1, 1, 12'h456);
        check("s1_addr_209", addr_f1, 6'd0);
        check("s1_hc302_fg", rgb1, 12'hFFF);
        pix(303, 209, 1, 1, 12'h456); check("s1_hc303_fg", rgb1, 12'hFFF);
        pix(301, 209, 1, 1, 12'h456); check("s1_hc301_bg", rgb1, 12'h456);
        pix(415, 209, 1, 1, 12'h456); check("s1_last_fg", rgb1, 12'hFFF);
        pix(416, 209, 1, 1, 12'h456); check("s1_past_bg", rgb1, 12'h456);
        pix(302, 210, 1, 1, 12'h456);
        check("s1_addr_210", addr_f1, 6'd1);
        check("s1_row1_bg", rgb1, 12'h456);

        // Blanking and enable.
        pix(295, 208, 0, 1, 12'h789); check("blank_black", rgb0, 12'h000);
        pix(295, 208, 1, 0, 12'h789); check("en_off_bg", rgb0, 12'h789);

        // Blink on dut2 from a known reset state.
        reset_pulse();
        for (int k = 0; k < 6; k++) begin
            hc = 10'd400; vc = 10'd100; vidon = 1'b1; vsync_in = 1'b0;
            tick(1);
            vsync_in = 1'b1;
            tick(1);
            pix(295, 208, 1, 1, 12'h00F);
            check($sformatf("blink_edge%0d", k + 1), rgb2, blink_exp[k] ? 12'hFFF : 12'h00F);
            check($sformatf("noblink_edge%0d", k + 1), rgb0, 12'hFFF);
        end

        // Reset mid-frame with hsync active inside the window.
        hc = 10'd295; vc = 10'd208; vidon = 1'b1; overlay_en = 1'b1;
        bg_rgb = 12'h00F; hsync_in = 1'b0; vsync_in = 1'b1;
        tick(2);
        check("pre_rst_rgb", rgb0, 12'hFFF);
        check("pre_rst_hsync", hs0, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        check("async_rgb", rgb0, 12'h000);
        check("async_hsync", hs0, 1'b1);
        check("async_vsync", vs0, 1'b1);
        check("async_rgb_s1", rgb1, 12'h000);
        check("async_hsync_s1", hs1, 1'b1);
        check("async_vsync_blk", vs2, 1'b1);
        #8 rst_n = 1'b1;
        tick(1);
        check("refill1_rgb", rgb0, 12'h000);
        check("refill1_hsync", hs0, 1'b1);
        tick(1);
        check("refill2_rgb", rgb0, 12'hFFF);
        check("refill2_hsync", hs0, 1'b0);
        check("refill2_vsync", vs1, 1'b1);
        check("rst_blink_on", rgb2, 12'hFFF);
        check("rst_hsync_blk", hs2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
